rst_seq_ctrl: RTL and testbench

Reset sequencer that releases up to G_NUM_DOMAINS downstream reset domains one at a time, in index order, after a power-on hold period. Each domain may report readiness (PLL lock, init done) before the next one is released. Each o_rst_n bit feeds the i_rst_n input of a rst_sync instance in its destination clock domain. The block sits at the top of the clock/reset tree and is the single source of sequenced resets in the design.

---
 rtl/rst_seq_ctrl_pkg.sv | 32 +++
 rtl/rst_seq_ctrl_if.sv | 21 ++
 rtl/rst_seq_ctrl_sig_sync.sv | 20 ++
 rtl/rst_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// rtl/rst_seq_ctrl_pkg.sv - Shared state encodings and helpers for the reset sequencer
package rst_seq_ctrl_pkg;

  // Sequencer states, 3-bit binary
  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_GAP      = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  // Width of one shared counter able to reach the largest of three counts
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // Select bit i of a domain vector widened to 16 bits
  function automatic logic bit_sel(input logic [15:0] v, input logic [3:0] i);
    return v[i];
  endfunction

  // One-hot vector with bit i set
  function automatic logic [15:0] dom_bit(input logic [3:0] i);
    return 16'h0001 << i;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - Request/status bundle between the reset sequencer and its user
interface rst_seq_ctrl_if #(
  parameter int G_NUM_DOMAINS = 4
) ();
  logic                     i_sw_rst;
  logic [G_NUM_DOMAINS-1:0] i_ack;
  logic [G_NUM_DOMAINS-1:0] o_rst_n;
  logic                     o_done;
  logic                     o_err;
  logic [3:0]               o_idx;

  modport master (
    output i_sw_rst, i_ack,
    input  o_rst_n, o_done, o_err, o_idx
  );

  modport slave (
    input  i_sw_rst, i_ack,
    output o_rst_n, o_done, o_err, o_idx
  );
endinterface

// File: rtl/rst_seq_ctrl_sig_sync.sv
// rtl/rst_seq_ctrl_sig_sync.sv - One-bit two-flop synchronizer, async active-high reset to 0
module rst_seq_ctrl_sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-stage capture of an asynchronous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - Sequenced reset release for downstream domains (timeout option: RST_SEQ_TIMEOUT_EN)
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int                       G_NUM_DOMAINS    = 4,
  parameter int                       G_HOLD_CYCLES    = 8,
  parameter int                       G_GAP_CYCLES     = 4,
  parameter int                       G_TIMEOUT_CYCLES = 32,
  parameter logic [G_NUM_DOMAINS-1:0] G_ACK_MASK       = '0
) (
  input logic           clk,
  input logic           i_rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int               CNT_W     = cnt_width(G_HOLD_CYCLES, G_GAP_CYCLES, G_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(G_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(G_GAP_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(G_TIMEOUT_CYCLES - 1);
`endif
  localparam logic [3:0]       LAST_IDX  = 4'(G_NUM_DOMAINS - 1);

  logic [G_NUM_DOMAINS-1:0] ack_s;
  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_inc;
  logic [3:0]               idx_q;
  logic [3:0]               tgt_idx;
  logic [G_NUM_DOMAINS-1:0] rst_n_q;
  logic [G_NUM_DOMAINS-1:0] tgt_bit;
  logic                     done_q;
  logic                     tgt_masked;
  logic                     tgt_last;
  logic                     ack_cur;
  logic                     ack_armed;
`ifdef RST_SEQ_TIMEOUT_EN
  logic                     err_q;
`endif

  for (genvar g = 0; g < G_NUM_DOMAINS; g++) begin : g_ack_sync
    rst_seq_ctrl_sig_sync u_sync (
      .clk (clk),
      .rst (i_rst),
      .d   (bus.i_ack[g]),
      .q   (ack_s[g])
    );
  end

  // Saturating increment so the shared counter never wraps
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Domain released next: domain 0 out of HOLD, the following one out of GAP
  assign tgt_idx    = (state_q == ST_GAP) ? idx_q + 4'd1 : 4'd0;
  assign tgt_bit    = G_NUM_DOMAINS'(dom_bit(tgt_idx));
  assign tgt_masked = bit_sel(16'(G_ACK_MASK), tgt_idx);
  assign tgt_last   = (tgt_idx == LAST_IDX);

  // The synchronized sample seen one edge after a release was taken while the
  // domain was still in reset, so acks only count from the second WAIT_ACK edge.
  assign ack_cur   = bit_sel(16'(ack_s), idx_q);
  assign ack_armed = (cnt_q != '0);

  // Sequencer FSM: hold, release domains in order, wait for acks, catch timeouts
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else if (bus.i_sw_rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HOLD, ST_GAP: begin
          if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : GAP_LAST)) begin
            rst_n_q <= rst_n_q | tgt_bit;
            idx_q   <= tgt_idx;
            cnt_q   <= '0;
            if (!tgt_masked) begin
              state_q <= ST_WAIT_ACK;
            end else if (tgt_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_WAIT_ACK: begin
`ifdef RST_SEQ_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            rst_n_q <= '0;
          end else
`endif
          if (ack_armed && ack_cur) begin
            cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_DONE, ST_ERROR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  assign bus.o_rst_n = rst_n_q;
  assign bus.o_done  = done_q;
  assign bus.o_idx   = idx_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.o_err   = err_q;
`else
  assign bus.o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - Self-checking bench for rst_seq_ctrl (covers both RST_SEQ_TIMEOUT_EN builds)
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int TO   = 32;
  localparam int MAXE = 160;
  localparam int INF  = 1 << 30;

  typedef struct {
    int         e;
    logic [3:0] rst_n;
    logic       done;
    logic       err;
    logic [3:0] idx;
  } vec_t;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  vec_t qa[$];
  vec_t qb[$];
  logic [3:0] hist  [2][MAXE+1];
  logic [9:0] exp_v [2][MAXE+1];

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.G_NUM_DOMAINS(N)) bus_a ();
  rst_seq_ctrl_if #(.G_NUM_DOMAINS(N)) bus_b ();

  rst_seq_ctrl #(
    .G_NUM_DOMAINS(N), .G_HOLD_CYCLES(HOLD), .G_GAP_CYCLES(GAP),
    .G_TIMEOUT_CYCLES(TO), .G_ACK_MASK(4'b0000)
  ) dut_a (.clk(clk), .i_rst(i_rst), .bus(bus_a.slave));

  rst_seq_ctrl #(
    .G_NUM_DOMAINS(N), .G_HOLD_CYCLES(HOLD), .G_GAP_CYCLES(GAP),
    .G_TIMEOUT_CYCLES(TO), .G_ACK_MASK(4'b0110)
  ) dut_b (.clk(clk), .i_rst(i_rst), .bus(bus_b.slave));

  function automatic logic [9:0] pk(logic [3:0] r, logic d, logic er, logic [3:0] i);
    return {r, d, er, i};
  endfunction

  function automatic vec_t v(int e, logic [3:0] r, logic d, logic er, logic [3:0] i);
    vec_t t;
    t.e = e; t.rst_n = r; t.done = d; t.err = er; t.idx = i;
    return t;
  endfunction

  function automatic logic [9:0] obs_a();
    return pk(bus_a.o_rst_n, bus_a.o_done, bus_a.o_err, bus_a.o_idx);
  endfunction

  function automatic logic [9:0] obs_b();
    return pk(bus_b.o_rst_n, bus_b.o_done, bus_b.o_err, bus_b.o_idx);
  endfunction

  task automatic chk(input string name, input int e, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got rst_n=%b done=%b err=%b idx=%0d, want rst_n=%b done=%b err=%b idx=%0d",
               name, e, act[9:6], act[5], act[4], act[3:0], exp[9:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    bus_a.i_sw_rst = 1'b0; bus_b.i_sw_rst = 1'b0;
    bus_a.i_ack = '0;      bus_b.i_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 0, obs_a(), pk(4'b0000, 1'b0, 1'b0, 4'd0));
    chk("reset_b", 0, obs_b(), pk(4'b0000, 1'b0, 1'b0, 4'd0));
    i_rst = 1'b0;
    edge_n = 0;
  endtask

  // Steps to edge 'last', pulsing i_sw_rst of dut_a on edges sw_lo..sw_hi,
  // checking every table entry whose edge is reached.
  task automatic run_tbl(input string name, input int last, input int sw_lo, input int sw_hi);
    while (edge_n < last) begin
      bus_a.i_sw_rst = (edge_n + 1 >= sw_lo) && (edge_n + 1 <= sw_hi);
      step();
      foreach (qa[i])
        if (qa[i].e == edge_n)
          chk({name, "_a"}, edge_n, obs_a(), pk(qa[i].rst_n, qa[i].done, qa[i].err, qa[i].idx));
      foreach (qb[i])
        if (qb[i].e == edge_n)
          chk({name, "_b"}, edge_n, obs_b(), pk(qb[i].rst_n, qb[i].done, qb[i].err, qb[i].idx));
    end
    bus_a.i_sw_rst = 1'b0;
  endtask

  // Reference: walk the domains in order using the timing rules directly.
  // An ack driven for edge x (x >= release edge) is acted on at edge x+2.
  task automatic build_model(input int d, input logic [3:0] mask);
    int rel[N];
    int done_e, err_e, err_k, r, x, act, idx;
    bit stop;
    logic [3:0] rn;
    for (int k = 0; k < N; k++) rel[k] = INF;
    done_e = INF; err_e = INF; err_k = 0; r = HOLD; stop = 1'b0;
    for (int k = 0; k < N && !stop; k++) begin
      rel[k] = r;
      if (mask[k]) begin
        if (k == N - 1) done_e = r;
        else r = r + GAP;
      end else begin
        x = r;
        while (x <= MAXE && !hist[d][x][k]) x++;
        act = (x > MAXE) ? INF : x + 2;
`ifdef RST_SEQ_TIMEOUT_EN
        if (act >= r + TO) begin
          err_e = r + TO; err_k = k; act = INF;
        end
`endif
        if (act >= INF) stop = 1'b1;
        else if (k == N - 1) done_e = act;
        else r = act + GAP;
      end
    end
    for (int e = 1; e <= MAXE; e++) begin
      if (e >= err_e) begin
        exp_v[d][e] = pk(4'b0000, 1'b0, 1'b1, 4'(err_k));
      end else begin
        rn = '0; idx = 0;
        for (int k = 0; k < N; k++)
          if (rel[k] <= e) begin rn[k] = 1'b1; idx = k; end
        exp_v[d][e] = pk(rn, e >= done_e, 1'b0, 4'(idx));
      end
    end
  endtask

  initial begin
    int p;

    // Power-on with every ack high (dut_a) and masked middle domains (dut_b)
    qa.push_back(v( 7, 4'b0000, 0, 0, 0));
    qa.push_back(v( 8, 4'b0001, 0, 0, 0));
    qa.push_back(v( 9, 4'b0001, 0, 0, 0));
    qa.push_back(v(13, 4'b0001, 0, 0, 0));
    qa.push_back(v(14, 4'b0011, 0, 0, 1));
    qa.push_back(v(19, 4'b0011, 0, 0, 1));
    qa.push_back(v(20, 4'b0111, 0, 0, 2));
    qa.push_back(v(25, 4'b0111, 0, 0, 2));
    qa.push_back(v(26, 4'b1111, 0, 0, 3));
    qa.push_back(v(27, 4'b1111, 0, 0, 3));
    qa.push_back(v(28, 4'b1111, 1, 0, 3));
    qa.push_back(v(40, 4'b1111, 1, 0, 3));
    qb.push_back(v( 8, 4'b0001, 0, 0, 0));
    qb.push_back(v(13, 4'b0001, 0, 0, 0));
    qb.push_back(v(14, 4'b0011, 0, 0, 1));
    qb.push_back(v(17, 4'b0011, 0, 0, 1));
    qb.push_back(v(18, 4'b0111, 0, 0, 2));
    qb.push_back(v(21, 4'b0111, 0, 0, 2));
    qb.push_back(v(22, 4'b1111, 0, 0, 3));
    qb.push_back(v(23, 4'b1111, 0, 0, 3));
    qb.push_back(v(24, 4'b1111, 1, 0, 3));

    do_reset();
    bus_a.i_ack = 4'b1111;
    bus_b.i_ack = 4'b1001;
    run_tbl("poweron", 40, 0, -1);

    // Asynchronous reset while both are done, away from any clock edge
    #3 i_rst = 1'b1;
    #1;
    chk("async_done_a", edge_n, obs_a(), pk(4'b0000, 1'b0, 1'b0, 4'd0));
    chk("async_done_b", edge_n, obs_b(), pk(4'b0000, 1'b0, 1'b0, 4'd0));

    // Software re-sequence pulse at edge 17 during GAP
    qa.delete(); qb.delete();
    qa.push_back(v(16, 4'b0011, 0, 0, 1));
    qa.push_back(v(17, 4'b0000, 0, 0, 0));
    qa.push_back(v(24, 4'b0000, 0, 0, 0));
    qa.push_back(v(25, 4'b0001, 0, 0, 0));
    qa.push_back(v(31, 4'b0011, 0, 0, 1));
    qa.push_back(v(37, 4'b0111, 0, 0, 2));
    qa.push_back(v(43, 4'b1111, 0, 0, 3));
    qa.push_back(v(44, 4'b1111, 0, 0, 3));
    qa.push_back(v(45, 4'b1111, 1, 0, 3));
    do_reset();
    bus_a.i_ack = 4'b1111;
    run_tbl("sw_pulse", 46, 17, 17);

    // Level-held software reset keeps the block in HOLD
    qa.delete();
    qa.push_back(v(30, 4'b0000, 0, 0, 0));
    qa.push_back(v(37, 4'b0000, 0, 0, 0));
    qa.push_back(v(38, 4'b0001, 0, 0, 0));
    qa.push_back(v(44, 4'b0011, 0, 0, 1));
    do_reset();
    bus_a.i_ack = 4'b1111;
    run_tbl("sw_level", 44, 3, 30);

    // Asynchronous reset mid-WAIT_ACK
    qa.delete();
    qa.push_back(v(12, 4'b0001, 0, 0, 0));
    do_reset();
    run_tbl("wait_ack", 12, 0, -1);
    #3 i_rst = 1'b1;
    #1;
    chk("async_wait_a", edge_n, obs_a(), pk(4'b0000, 1'b0, 1'b0, 4'd0));

    qa.delete();
`ifdef RST_SEQ_TIMEOUT_EN
    // Domain 1 never acks: ERROR at 14+32, held afterwards
    qa.push_back(v(  8, 4'b0001, 0, 0, 0));
    qa.push_back(v( 14, 4'b0011, 0, 0, 1));
    qa.push_back(v( 45, 4'b0011, 0, 0, 1));
    qa.push_back(v( 46, 4'b0000, 0, 1, 1));
    qa.push_back(v(146, 4'b0000, 0, 1, 1));
    do_reset();
    bus_a.i_ack = 4'b1101;
    run_tbl("timeout", 146, 0, -1);
`else
    // Domain 2 stalls indefinitely, then resumes when its ack arrives
    qa.push_back(v(   8, 4'b0001, 0, 0, 0));
    qa.push_back(v(  20, 4'b0111, 0, 0, 2));
    qa.push_back(v(1000, 4'b0111, 0, 0, 2));
    do_reset();
    bus_a.i_ack = 4'b1011;
    run_tbl("stall", 1000, 0, -1);
    qa.delete();
    qa.push_back(v(1006, 4'b0111, 0, 0, 2));
    qa.push_back(v(1007, 4'b1111, 0, 0, 3));
    qa.push_back(v(1008, 4'b1111, 0, 0, 3));
    qa.push_back(v(1009, 4'b1111, 1, 0, 3));
    bus_a.i_ack = 4'b1111;
    run_tbl("resume", 1010, 0, -1);
`endif

    // Randomized ack waveforms against the reference walk
    for (int t = 0; t < 6; t++) begin
      p = $urandom_range(2, 40);
      for (int d = 0; d < 2; d++)
        for (int x = 0; x <= MAXE; x++)
          for (int k = 0; k < N; k++)
            hist[d][x][k] = ($urandom_range(0, 99) < p);
      build_model(0, 4'b0000);
      build_model(1, 4'b0110);
      do_reset();
      for (int e = 1; e <= MAXE; e++) begin
        bus_a.i_ack = hist[0][e];
        bus_b.i_ack = hist[1][e];
        step();
        chk("rand_a", e, obs_a(), exp_v[0][e]);
        chk("rand_b", e, obs_b(), exp_v[1][e]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
